// File: rtl/lsu_pkg.sv
// Shared encodings and FSM state type for the memory-stage load/store unit.
package lsu_pkg;

   localparam logic [2:0] LD_B    = 3'b000;
   localparam logic [2:0] LD_H    = 3'b001;
   localparam logic [2:0] LD_W    = 3'b010;
   localparam logic [2:0] LD_NONE = 3'b011;
   localparam logic [2:0] LD_BU   = 3'b100;
   localparam logic [2:0] LD_HU   = 3'b101;

   localparam logic [2:0] ST_B    = 3'b000;
   localparam logic [2:0] ST_H    = 3'b001;
   localparam logic [2:0] ST_W    = 3'b010;
   localparam logic [2:0] ST_NONE = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } lsu_state_t;

   // Unlisted encodings behave exactly like NONE.
   function automatic logic ld_is_valid(input logic [2:0] c);
      return (c == LD_B) || (c == LD_H) || (c == LD_W) || (c == LD_BU) || (c == LD_HU);
   endfunction

   function automatic logic st_is_valid(input logic [2:0] c);
      return (c == ST_B) || (c == ST_H) || (c == ST_W);
   endfunction

   // Access size: 0 = byte, 1 = half, 2 = word.
   function automatic logic [1:0] acc_size(input logic is_st, input logic [2:0] rd,
                                           input logic [2:0] wr);
      logic [1:0] s;
      s = 2'd0;
      if (is_st) begin
         if (wr == ST_H)      s = 2'd1;
         else if (wr == ST_W) s = 2'd2;
      end else begin
         if ((rd == LD_H) || (rd == LD_HU)) s = 2'd1;
         else if (rd == LD_W)               s = 2'd2;
      end
      return s;
   endfunction

endpackage

// File: rtl/lsu_m_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_m_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   // Request transfers on a cycle where dbus_req_valid && dbus_req_ready; once
   // raised, valid and payload hold until that cycle. A load's response is a
   // single dbus_rsp_valid pulse carrying dbus_rdata; there is no rsp ready.
   logic              dbus_req_valid;
   logic              dbus_req_ready;
   logic [ADDR_W-1:0] dbus_addr;
   logic              dbus_we;
   logic [3:0]        dbus_wmask;
   logic [DATA_W-1:0] dbus_wdata;
   logic              dbus_rsp_valid;
   logic [DATA_W-1:0] dbus_rdata;

   modport master (
      output dbus_req_valid, dbus_addr, dbus_we, dbus_wmask, dbus_wdata,
      input  dbus_req_ready, dbus_rsp_valid, dbus_rdata
   );

   modport slave (
      input  dbus_req_valid, dbus_addr, dbus_we, dbus_wmask, dbus_wdata,
      output dbus_req_ready, dbus_rsp_valid, dbus_rdata
   );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a response word and extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  ld_op,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {off, 3'b000};
      case (ld_op)
         LD_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         LD_BU:   data = {24'h0, shifted[7:0]};
         LD_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         LD_HU:   data = {16'h0, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_m.sv
// Memory-stage load/store unit: one bus access at a time, stalls the pipe until done.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of masking.
module lsu_m
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        rd_ctrl_m,
   input  logic [2:0]        wr_ctrl_m,
   input  logic [ADDR_W-1:0] addr_m,
   input  logic [DATA_W-1:0] wdata_m,
   input  logic              flush_m,
   lsu_m_if.master           dbus,
   output logic [DATA_W-1:0] load_data_m,
   output logic              stall_m,
   output logic              misalign_m,
   output lsu_state_t        dbg_state
);

   lsu_state_t        state_q, state_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        ld_op_q, ld_op_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic              misalign_q, misalign_d;

   logic              ld_req, st_req, access, trap, stall_c;
   logic [1:0]        size, off_eff;
   logic [3:0]        wmask_new;
   logic [DATA_W-1:0] wdata_new, aligned;

   lsu_load_align u_align (
      .word  (dbus.dbus_rdata),
      .off   (off_q),
      .ld_op (ld_op_q),
      .data  (aligned)
   );

   // Store wins when both controls request an access.
   always_comb begin
      ld_req  = ld_is_valid(rd_ctrl_m);
      st_req  = st_is_valid(wr_ctrl_m);
      access  = ld_req | st_req;
      size    = acc_size(st_req, rd_ctrl_m, wr_ctrl_m);
      off_eff = 2'b00;
      case (size)
         2'd0:    off_eff = addr_m[1:0];
         2'd1:    off_eff = {addr_m[1], 1'b0};
         default: off_eff = 2'b00;
      endcase
`ifdef MISALIGN_TRAP_EN
      trap = ((size == 2'd1) && addr_m[0]) || ((size == 2'd2) && (addr_m[1:0] != 2'b00));
`else
      trap = 1'b0;
`endif
      wmask_new = 4'b1111;
      wdata_new = '0;
      if (st_req) begin
         case (size)
            2'd0: begin
               wmask_new = 4'b0001 << off_eff;
               wdata_new = {4{wdata_m[7:0]}};
            end
            2'd1: begin
               wmask_new = 4'b0011 << off_eff;
               wdata_new = {2{wdata_m[15:0]}};
            end
            default: begin
               wmask_new = 4'b1111;
               wdata_new = wdata_m;
            end
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      req_valid_d = req_valid_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wmask_d     = wmask_q;
      wdata_d     = wdata_q;
      off_d       = off_q;
      ld_op_d     = ld_op_q;
      load_data_d = load_data_q;
      misalign_d  = 1'b0;
      stall_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (access && !flush_m) begin
               if (trap) begin
                  misalign_d = 1'b1;
               end else begin
                  stall_c     = 1'b1;
                  state_d     = REQ;
                  req_valid_d = 1'b1;
                  addr_d      = {addr_m[ADDR_W-1:2], 2'b00};
                  we_d        = st_req;
                  wmask_d     = wmask_new;
                  wdata_d     = wdata_new;
                  off_d       = off_eff;
                  ld_op_d     = rd_ctrl_m;
               end
            end
         end
         REQ: begin
            stall_c = 1'b1;
            // An accepted request cannot be cancelled, so ready beats flush.
            if (dbus.dbus_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = we_q ? DONE : WAIT_RSP;
            end else if (flush_m) begin
               req_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         WAIT_RSP: begin
            stall_c = 1'b1;
            if (dbus.dbus_rsp_valid) begin
               load_data_d = aligned;
               state_d     = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         req_valid_q <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wmask_q     <= 4'b0000;
         wdata_q     <= '0;
         off_q       <= 2'b00;
         ld_op_q     <= LD_NONE;
         load_data_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wmask_q     <= wmask_d;
         wdata_q     <= wdata_d;
         off_q       <= off_d;
         ld_op_q     <= ld_op_d;
         load_data_q <= load_data_d;
         misalign_q  <= misalign_d;
      end
   end

   assign dbus.dbus_req_valid = req_valid_q;
   assign dbus.dbus_addr      = addr_q;
   assign dbus.dbus_we        = we_q;
   assign dbus.dbus_wmask     = wmask_q;
   assign dbus.dbus_wdata     = wdata_q;
   assign load_data_m         = load_data_q;
   assign stall_m             = stall_c;
   assign misalign_m          = misalign_q;
   assign dbg_state           = state_q;

endmodule

// File: tb/tb_lsu_m.sv
// Directed bench for lsu_m: scoreboard queues for bus requests and completions.
module tb_lsu_m;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rd_ctrl_m, wr_ctrl_m;
   logic [31:0] addr_m, wdata_m;
   logic        flush_m;
   logic [31:0] load_data_m;
   logic        stall_m, misalign_m;
   lsu_state_t  dbg_state;

   lsu_m_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

   lsu_m #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_ctrl_m   (rd_ctrl_m),
      .wr_ctrl_m   (wr_ctrl_m),
      .addr_m      (addr_m),
      .wdata_m     (wdata_m),
      .flush_m     (flush_m),
      .dbus        (dbus),
      .load_data_m (load_data_m),
      .stall_m     (stall_m),
      .misalign_m  (misalign_m),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [68:0] req_exp_q[$];   // {addr, we, wmask, wdata}
   logic [31:0] done_exp_q[$];
   int          wait_cnt = 0;
   int          rsp_delay = 0;
   int          rsp_cnt = 0;
   logic [31:0] rsp_word = 32'h0;
   logic [31:0] last_load = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model plus monitor; everything happens mid-cycle on the falling edge.
   task automatic mem_monitor();
      logic [68:0] e;
      forever begin
         @(negedge clk);
         if (dbg_state == DONE) begin
            if (done_exp_q.size() == 0) begin
               n_cmp++;
               n_mis++;
               $display("FAIL unexpected_done: got state DONE expected no completion at %0t", $time);
            end else begin
               check("load_data", load_data_m, done_exp_q.pop_front());
            end
         end
         if (rsp_cnt == 1) begin
            dbus.dbus_rsp_valid = 1'b1;
            dbus.dbus_rdata     = rsp_word;
            rsp_cnt             = 0;
         end else begin
            dbus.dbus_rsp_valid = 1'b0;
            if (rsp_cnt > 1) rsp_cnt--;
         end
         if (dbus.dbus_req_valid) begin
            if (wait_cnt > 0) begin
               dbus.dbus_req_ready = 1'b0;
               wait_cnt--;
            end else begin
               dbus.dbus_req_ready = 1'b1;
               if (req_exp_q.size() == 0) begin
                  n_cmp++;
                  n_mis++;
                  $display("FAIL unexpected_req: got addr %h expected no request", dbus.dbus_addr);
               end else begin
                  e = req_exp_q.pop_front();
                  check("req_addr", dbus.dbus_addr, e[68:37]);
                  check("req_we_mask", {27'h0, dbus.dbus_we, dbus.dbus_wmask}, {27'h0, e[36:32]});
                  if (e[36]) check("req_wdata", dbus.dbus_wdata, e[31:0]);
               end
               if (!dbus.dbus_we) rsp_cnt = rsp_delay + 1;
            end
         end else begin
            dbus.dbus_req_ready = 1'b0;
         end
      end
   endtask

   task automatic idle_inputs();
      rd_ctrl_m = LD_NONE;
      wr_ctrl_m = ST_NONE;
      addr_m    = 32'h0;
      wdata_m   = 32'h0;
      flush_m   = 1'b0;
   endtask

   // Presents one access, counts stall cycles until DONE, and checks payload stability.
   task automatic run_access(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output int n, output int vcyc, output int bad);
      logic [68:0] snap, cur;
      n = 0; vcyc = 0; bad = 0; snap = '0;
      @(posedge clk); #1;
      rd_ctrl_m = rd; wr_ctrl_m = wr; addr_m = addr; wdata_m = wdata;
      @(negedge clk);
      while (stall_m && n < 60) begin
         n++;
         if (dbus.dbus_req_valid) begin
            cur = {dbus.dbus_addr, dbus.dbus_we, dbus.dbus_wmask, dbus.dbus_wdata};
            if (vcyc == 0) snap = cur;
            else if (cur !== snap) bad++;
            vcyc++;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_load(input logic [2:0] rd, input logic [31:0] addr, input logic [31:0] word,
                          input logic [31:0] exp, input int exp_stall, input int wait_c, input int dly);
      int n, v, b;
      req_exp_q.push_back({addr & ~32'h3, 1'b0, 4'hF, 32'h0});
      done_exp_q.push_back(exp);
      last_load = exp; rsp_word = word; wait_cnt = wait_c; rsp_delay = dly;
      run_access(rd, ST_NONE, addr, 32'h0, n, v, b);
      check("load_stall_cycles", 32'(n), 32'(exp_stall));
   endtask

   task automatic do_store(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                           input int exp_stall, input int wait_c, output int v, output int b);
      int n;
      req_exp_q.push_back({addr & ~32'h3, 1'b1, exp_mask, exp_wdata});
      done_exp_q.push_back(last_load);
      wait_cnt = wait_c;
      run_access(rd, wr, addr, data, n, v, b);
      check("store_stall_cycles", 32'(n), 32'(exp_stall));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_valid"}, {31'h0, dbus.dbus_req_valid}, 32'h0);
      check({tag, "_we"}, {31'h0, dbus.dbus_we}, 32'h0);
      check({tag, "_wmask"}, {28'h0, dbus.dbus_wmask}, 32'h0);
      check({tag, "_addr"}, dbus.dbus_addr, 32'h0);
      check({tag, "_wdata"}, dbus.dbus_wdata, 32'h0);
      check({tag, "_load_data"}, load_data_m, 32'h0);
      check({tag, "_misalign"}, {31'h0, misalign_m}, 32'h0);
      check({tag, "_stall"}, {31'h0, stall_m}, 32'h0);
   endtask

   initial begin
      int v, b, cnt_v, cnt_s, cnt_m;
      rst = 1'b1;
      idle_inputs();
      dbus.dbus_req_ready = 1'b0;
      dbus.dbus_rsp_valid = 1'b0;
      dbus.dbus_rdata     = 32'h0;
      fork
         mem_monitor();
      join_none
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset");

      do_load(LD_W, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0, 0);
      do_store(LD_NONE, ST_B, 32'h203, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 2, 0, v, b);
      do_load(LD_B, 32'h102, 32'h0080FF00, 32'hFFFFFF80, 3, 0, 0);
      do_load(LD_BU, 32'h102, 32'h0080FF00, 32'h00000080, 3, 0, 0);

      // Ready held low for 5 cycles: 6 valid cycles with a frozen payload.
      do_store(LD_NONE, ST_H, 32'h2, 32'hABCD1234, 4'b1100, 32'h12341234, 7, 5, v, b);
      check("sh_valid_cycles", 32'(v), 32'd6);
      check("sh_payload_changes", 32'(b), 32'd0);

      do_load(LD_H, 32'h106, 32'hBEEF1234, 32'hFFFFBEEF, 3, 0, 0);
      do_load(LD_HU, 32'h104, 32'h12348001, 32'h00008001, 3, 0, 0);
      do_load(LD_W, 32'h108, 32'h0BADF00D, 32'h0BADF00D, 5, 0, 2);
      rsp_delay = 0;
      do_store(LD_W, ST_W, 32'h300, 32'h11223344, 4'b1111, 32'h11223344, 2, 0, v, b);
      do_store(LD_NONE, ST_B, 32'h101, 32'h0000005A, 4'b0010, 32'h5A5A5A5A, 2, 0, v, b);

      // Unlisted control encodings start nothing.
      @(posedge clk); #1;
      rd_ctrl_m = 3'b110; wr_ctrl_m = 3'b011; addr_m = 32'h600;
      cnt_v = 0; cnt_s = 0;
      repeat (3) begin
         @(negedge clk);
         if (dbus.dbus_req_valid) cnt_v++;
         if (stall_m) cnt_s++;
      end
      @(posedge clk); #1 idle_inputs();
      check("none_enc_valid_cycles", 32'(cnt_v), 32'd0);
      check("none_enc_stall_cycles", 32'(cnt_s), 32'd0);

      // Flush while the request waits for ready: no handshake, no DONE.
      wait_cnt = 10;
      @(posedge clk); #1;
      rd_ctrl_m = LD_W; addr_m = 32'h400;
      @(posedge clk); #1;
      flush_m = 1'b1; rd_ctrl_m = LD_NONE;
      @(negedge clk);
      check("flush_req_valid_before", {31'h0, dbus.dbus_req_valid}, 32'h1);
      @(posedge clk); #1 flush_m = 1'b0;
      @(negedge clk);
      check("flush_valid_dropped", {31'h0, dbus.dbus_req_valid}, 32'h0);
      check("flush_stall_released", {31'h0, stall_m}, 32'h0);
      wait_cnt = 0;
      repeat (2) @(posedge clk);

      // Reset while waiting for the response; the late response must be ignored.
      rsp_delay = 4; rsp_word = 32'h77777777;
      req_exp_q.push_back({32'h500, 1'b0, 4'hF, 32'h0});
      @(posedge clk); #1;
      rd_ctrl_m = LD_W; addr_m = 32'h500;
      @(posedge clk); #1 rd_ctrl_m = LD_NONE;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      last_load = 32'h0;
      cnt_v = 0; cnt_s = 0;
      repeat (8) begin
         @(negedge clk);
         if (dbus.dbus_req_valid) cnt_v++;
         if (stall_m) cnt_s++;
      end
      rsp_delay = 0;
      check("post_rst_valid_cycles", 32'(cnt_v), 32'd0);
      check("post_rst_stall_cycles", 32'(cnt_s), 32'd0);
      check_reset_values("post_rst");

`ifdef MISALIGN_TRAP_EN
      cnt_v = 0; cnt_s = 0; cnt_m = 0;
      @(posedge clk); #1;
      rd_ctrl_m = LD_W; addr_m = 32'h102;
      @(negedge clk);
      if (stall_m) cnt_s++;
      @(posedge clk); #1 idle_inputs();
      repeat (4) begin
         @(negedge clk);
         if (dbus.dbus_req_valid) cnt_v++;
         if (stall_m) cnt_s++;
         if (misalign_m) cnt_m++;
      end
      check("misalign_pulses", 32'(cnt_m), 32'd1);
      check("misalign_valid_cycles", 32'(cnt_v), 32'd0);
      check("misalign_stall_cycles", 32'(cnt_s), 32'd0);
      check("misalign_load_data_kept", load_data_m, last_load);
`else
      cnt_m = 0;
      do_load(LD_W, 32'h102, 32'hCAFEF00D, 32'hCAFEF00D, 3, 0, 0);
      do_store(LD_NONE, ST_H, 32'h3, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 2, 0, v, b);
      repeat (3) begin
         @(negedge clk);
         if (misalign_m) cnt_m++;
      end
      check("misalign_tied_low", 32'(cnt_m), 32'd0);
`endif

      repeat (3) @(posedge clk);
      check("req_queue_drained", 32'(req_exp_q.size()), 32'd0);
      check("done_queue_drained", 32'(done_exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
